plic_claim_sequencer: RTL

- Hardware AXI master that runs the claim/complete protocol for one target context of the Andes PLIC (nceplic100) on behalf of a non-CPU interrupt consumer, e.g. a DMA or mailbox engine.
- When the target's eip line is high, it reads the claim register and hands the interrupt ID to the consumer over a valid/ready port. It then waits for the consumer's done pulse and writes the same ID to the complete register.
- Sits beside the PLIC and connects to the PLIC AXI slave port through the APU interconnect.

---
 rtl/plic_claim_sequencer_if.sv | 72 +++++++
 rtl/plic_claim_sequencer.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/plic_claim_sequencer_if.sv
// AXI4 master/slave bundle used between plic_claim_sequencer and the PLIC slave port.
interface plic_claim_sequencer_if #(
    parameter int ADDR_W = 40,
    parameter int DATA_W = 64,
    parameter int ID_W   = 4
) ();
    logic              arvalid;
    logic              arready;
    logic [ADDR_W-1:0] araddr;
    logic [ID_W-1:0]   arid;
    logic [7:0]        arlen;
    logic [2:0]        arsize;
    logic [1:0]        arburst;
    logic              arlock;
    logic [3:0]        arcache;
    logic [2:0]        arprot;

    logic              rvalid;
    logic              rready;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic [ID_W-1:0]   rid;
    logic              rlast;

    logic              awvalid;
    logic              awready;
    logic [ADDR_W-1:0] awaddr;
    logic [ID_W-1:0]   awid;
    logic [7:0]        awlen;
    logic [2:0]        awsize;
    logic [1:0]        awburst;
    logic              awlock;
    logic [3:0]        awcache;
    logic [2:0]        awprot;

    logic                  wvalid;
    logic                  wready;
    logic [DATA_W-1:0]     wdata;
    logic [DATA_W/8-1:0]   wstrb;
    logic                  wlast;

    logic              bvalid;
    logic              bready;
    logic [1:0]        bresp;
    logic [ID_W-1:0]   bid;

    modport master (
        output arvalid, araddr, arid, arlen, arsize, arburst, arlock, arcache, arprot,
        input  arready,
        input  rvalid, rdata, rresp, rid, rlast,
        output rready,
        output awvalid, awaddr, awid, awlen, awsize, awburst, awlock, awcache, awprot,
        input  awready,
        output wvalid, wdata, wstrb, wlast,
        input  wready,
        input  bvalid, bresp, bid,
        output bready
    );

    modport slave (
        input  arvalid, araddr, arid, arlen, arsize, arburst, arlock, arcache, arprot,
        output arready,
        output rvalid, rdata, rresp, rid, rlast,
        input  rready,
        input  awvalid, awaddr, awid, awlen, awsize, awburst, awlock, awcache, awprot,
        output awready,
        input  wvalid, wdata, wstrb, wlast,
        output wready,
        output bvalid, bresp, bid,
        input  bready
    );
endinterface

// File: rtl/plic_claim_sequencer.sv
// AXI master running PLIC claim/complete for one target context on behalf of a hardware consumer.
// Optional service watchdog: define PLIC_CLAIM_TIMEOUT_EN.
module plic_claim_sequencer #(
    parameter int          AXI_ADDR_WIDTH = 40,
    parameter int          AXI_DATA_WIDTH = 64,
    parameter int          AXI_ID_WIDTH   = 4,
    parameter int          AXI_ID         = 0,
    parameter logic [63:0] PLIC_BASE_ADDR = 64'h0,
    parameter int          TARGET_INDEX   = 0,
    parameter int          ID_WIDTH       = 10,
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_eip,
    output logic                o_irq_valid,
    output logic [ID_WIDTH-1:0] o_irq_id,
    input  logic                i_irq_ready,
    input  logic                i_irq_done,
    output logic                o_busy,
    output logic                o_err,
    input  logic                i_err_clear,
    output logic [15:0]         o_spurious_cnt,
    plic_claim_sequencer_if.master axi_m
);
    localparam int          ID_LSB = (AXI_DATA_WIDTH == 64) ? 32 : 0;
    localparam int          STRB_W = AXI_DATA_WIDTH / 8;
    localparam logic [63:0] CLAIM_ADDR64 = PLIC_BASE_ADDR + 64'h0020_0004
                                           + 64'h1000 * 64'(TARGET_INDEX);
    localparam logic [STRB_W-1:0] WSTRB = STRB_W'((AXI_DATA_WIDTH == 64) ? 32'hF0 : 32'hF);
    localparam logic [1:0]  RESP_OKAY = 2'b00;

    typedef enum logic [2:0] {
        IDLE, AR, R, DELIVER, SERVICE, WR, B
    } state_t;

    state_t              state_q;
    logic                arvalid_q, rready_q, awvalid_q, wvalid_q, bready_q;
    logic                irq_valid_q, err_q;
    logic [ID_WIDTH-1:0] irq_id_q;
    logic [15:0]         spur_q;

    logic [ID_WIDTH-1:0] claim_id;
    logic                aw_left, w_left;
    logic                complete_go, tmo_err;

    assign claim_id = axi_m.rdata[ID_LSB +: ID_WIDTH];
    // A channel is still outstanding unless its handshake happens this cycle
    assign aw_left  = awvalid_q & ~axi_m.awready;
    assign w_left   = wvalid_q  & ~axi_m.wready;

`ifdef PLIC_CLAIM_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] tmo_q;
    logic             tmo_hit;

    // Held at zero outside SERVICE, so it restarts on every entry
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            tmo_q <= '0;
        end else if (state_q != SERVICE) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_q + 1'b1;
        end
    end

    assign tmo_hit     = (state_q == SERVICE) && (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));
    assign complete_go = i_irq_done | tmo_hit;
    assign tmo_err     = tmo_hit & ~i_irq_done;
`else
    localparam int unsigned unused_timeout_cycles = TIMEOUT_CYCLES;
    assign complete_go = i_irq_done;
    assign tmo_err     = 1'b0;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= IDLE;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            irq_valid_q <= 1'b0;
            irq_id_q    <= '0;
            err_q       <= 1'b0;
            spur_q      <= '0;
        end else begin
            // Error events below are later assignments, so they override a same-cycle clear
            if (i_err_clear) begin
                err_q <= 1'b0;
            end
            case (state_q)
                IDLE: begin
                    if (i_eip) begin
                        arvalid_q <= 1'b1;
                        state_q   <= AR;
                    end
                end
                AR: begin
                    if (axi_m.arready) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state_q   <= R;
                    end
                end
                R: begin
                    if (axi_m.rvalid) begin
                        rready_q <= 1'b0;
                        if (axi_m.rresp != RESP_OKAY) begin
                            err_q   <= 1'b1;
                            state_q <= IDLE;
                        end else if (claim_id == '0) begin
                            if (spur_q != 16'hFFFF) begin
                                spur_q <= spur_q + 16'd1;
                            end
                            state_q <= IDLE;
                        end else begin
                            irq_id_q    <= claim_id;
                            irq_valid_q <= 1'b1;
                            state_q     <= DELIVER;
                        end
                    end
                end
                DELIVER: begin
                    if (i_irq_ready) begin
                        irq_valid_q <= 1'b0;
                        state_q     <= SERVICE;
                    end
                end
                SERVICE: begin
                    if (complete_go) begin
                        awvalid_q <= 1'b1;
                        wvalid_q  <= 1'b1;
                        state_q   <= WR;
                        if (tmo_err) begin
                            err_q <= 1'b1;
                        end
                    end
                end
                WR: begin
                    if (axi_m.awready) begin
                        awvalid_q <= 1'b0;
                    end
                    if (axi_m.wready) begin
                        wvalid_q <= 1'b0;
                    end
                    if (!aw_left && !w_left) begin
                        bready_q <= 1'b1;
                        state_q  <= B;
                    end
                end
                B: begin
                    if (axi_m.bvalid) begin
                        bready_q <= 1'b0;
                        state_q  <= IDLE;
                        if (axi_m.bresp != RESP_OKAY) begin
                            err_q <= 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign o_irq_valid    = irq_valid_q;
    assign o_irq_id       = irq_id_q;
    assign o_busy         = (state_q != IDLE);
    assign o_err          = err_q;
    assign o_spurious_cnt = spur_q;

    assign axi_m.arvalid = arvalid_q;
    assign axi_m.araddr  = CLAIM_ADDR64[AXI_ADDR_WIDTH-1:0];
    assign axi_m.arid    = AXI_ID_WIDTH'(AXI_ID);
    assign axi_m.arlen   = 8'd0;
    assign axi_m.arsize  = 3'b010;
    assign axi_m.arburst = 2'b01;
    assign axi_m.arlock  = 1'b0;
    assign axi_m.arcache = 4'd0;
    assign axi_m.arprot  = 3'd0;
    assign axi_m.rready  = rready_q;

    assign axi_m.awvalid = awvalid_q;
    assign axi_m.awaddr  = CLAIM_ADDR64[AXI_ADDR_WIDTH-1:0];
    assign axi_m.awid    = AXI_ID_WIDTH'(AXI_ID);
    assign axi_m.awlen   = 8'd0;
    assign axi_m.awsize  = 3'b010;
    assign axi_m.awburst = 2'b01;
    assign axi_m.awlock  = 1'b0;
    assign axi_m.awcache = 4'd0;
    assign axi_m.awprot  = 3'd0;

    // irq_id_q is stable from DELIVER until the next claim, so wdata needs no own register
    assign axi_m.wvalid = wvalid_q;
    assign axi_m.wdata  = {{(AXI_DATA_WIDTH-ID_WIDTH){1'b0}}, irq_id_q} << ID_LSB;
    assign axi_m.wstrb  = WSTRB;
    assign axi_m.wlast  = 1'b1;
    assign axi_m.bready = bready_q;

    logic unused_inputs;
    assign unused_inputs = ^{axi_m.rid, axi_m.rlast, axi_m.bid, axi_m.rdata};
endmodule
